// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter sequencer.
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_RET,
        SRC_BR,
        SRC_JR,
        SRC_TRAP
    } src_e;

    // Keeps the low log2(inc) bits clear and limits the mask to xlen bits.
    function automatic logic [63:0] align_mask(input int xlen, input int inc);
        logic [63:0] width_mask;
        width_mask = (xlen >= 64) ? '1 : ((64'd1 << xlen) - 64'd1);
        return width_mask & ~(64'(inc) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, replace-top, clear, and an
// overflow strobe when a push overwrites the oldest live entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty,
    output logic            ovf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_inc;
    logic [CW-1:0]   count_q;
    logic            full;
    logic            replace;
    logic            do_push;
    logic            do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(RAS_DEPTH));
    assign ptr_inc  = ptr_q + 1'b1;
    // Simultaneous push and pop on a non-empty stack swaps the top in place.
    assign replace  = push & pop & ~empty;
    assign do_push  = push & ~replace;
    assign do_pop   = pop & ~push & ~empty;
    assign ovf      = do_push & full & ~clear;
    assign top_data = mem[ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (clear) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (do_push) begin
            ptr_q <= ptr_inc;
            if (!full) begin
                count_q <= count_q + 1'b1;
            end
        end else if (do_pop) begin
            ptr_q   <= ptr_q - 1'b1;
            count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            if (replace) begin
                mem[ptr_q] <= push_data;
            end else if (do_push) begin
                mem[ptr_inc] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: prioritised redirect mux with zero-bubble bypass,
// sequential increment on handshake acceptance, and return prediction.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              OFF_W     = 26,
    parameter int              INC       = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] TRAP_PC   = XLEN'(32'h100),
    parameter int              RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             trap_i,
    input  logic             jr_i,
    input  logic [XLEN-1:0]  jr_target_i,
    input  logic             br_taken_i,
    input  logic [XLEN-1:0]  br_base_i,
    input  logic [OFF_W-1:0] br_off_i,
    input  logic             call_i,
    input  logic             ret_i,
    input  logic [XLEN-1:0]  ret_addr_i,
    input  logic             fetch_ready_i,
    output logic             fetch_valid_o,
    output logic [XLEN-1:0]  fetch_pc_o,
    output logic             flush_o,
    output logic             ras_empty_o,
    output logic             ras_ovf_o
);

    localparam logic [XLEN-1:0] ALIGN = XLEN'(align_mask(XLEN, INC));
    localparam logic [XLEN-1:0] INC_X = XLEN'(INC);

    src_e            src;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            ovf_q;
    logic            redirect;
    logic            ras_ok;
    logic            ras_empty;
    logic            ras_ovf;

    assign br_target = br_base_i + XLEN'($signed(br_off_i));

    always_comb begin
        src    = SRC_NONE;
        target = pc_q;
        if (trap_i) begin
            src    = SRC_TRAP;
            target = TRAP_PC;
        end else if (jr_i) begin
            src    = SRC_JR;
            target = jr_target_i;
        end else if (br_taken_i) begin
            src    = SRC_BR;
            target = br_target;
        end else if (ret_i && !ras_empty) begin
            src    = SRC_RET;
            target = ras_top;
        end
    end

    assign redirect      = (src != SRC_NONE);
    assign fetch_pc_o    = redirect ? (target & ALIGN) : pc_q;
    assign fetch_valid_o = valid_q;
    assign flush_o       = redirect & valid_q;
    assign ras_empty_o   = ras_empty;
    assign ras_ovf_o     = ovf_q;

    // Call/return bookkeeping is dropped whenever a stronger redirect wins.
    assign ras_ok = ~(trap_i | jr_i | br_taken_i);

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (call_i & ras_ok),
        .pop       (ret_i & ras_ok),
        .clear     (trap_i),
        .push_data (ret_addr_i),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .ovf       (ras_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            if (ras_ovf) begin
                ovf_q <= 1'b1;
            end
            if (valid_q && fetch_ready_i) begin
                pc_q <= fetch_pc_o + INC_X;
            end else if (redirect) begin
                pc_q <= fetch_pc_o;
            end
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage, successor to the single-width PC register. It selects the next fetch address from four redirect sources (trap, register jump, taken branch, predicted return) or sequential increment. It presents that address on a valid/ready fetch handshake and predicts returns with an internal return-address stack (RAS). It sits between decode/execute (redirect sources) and the instruction memory port.

## Interface
Parameters:
- XLEN, 32, address width
- OFF_W, 26, width of signed branch offset (sign-extended to XLEN internally)
- INC, 4, sequential increment in bytes; power of two
- RESET_PC, 0, PC after reset
- TRAP_PC, 32'h100, trap vector
- RAS_DEPTH, 4, return-stack entries (≥2, power of two)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- trap_i  in  1  trap redirect request
- jr_i  in  1  register-jump redirect request
- jr_target_i  in  XLEN  absolute jump target
- br_taken_i  in  1  taken-branch redirect request
- br_base_i  in  XLEN  PC of the branch instruction
- br_off_i  in  OFF_W  signed byte offset
- call_i  in  1  decode saw a call; push ret_addr_i
- ret_i  in  1  decode saw a return; pop and predict
- ret_addr_i  in  XLEN  return address to push
- fetch_ready_i  in  1  memory accepts fetch_pc_o this cycle
- fetch_valid_o  out  1  fetch request valid
- fetch_pc_o  out  XLEN  fetch address
- flush_o  out  1  a redirect was taken this cycle
- ras_empty_o  out  1  RAS holds no entries
- ras_ovf_o  out  1  sticky: a push overwrote a live entry

## Operation
- State: pc_q (XLEN), valid_q, RAS array + top pointer + count (0..RAS_DEPTH), ovf_q.
- Redirect priority: trap > jr > br_taken > ret (only if RAS non-empty) > none.
- Targets: trap → TRAP_PC; jr → jr_target_i; br → br_base_i + sext(br_off_i) (mod 2^XLEN); ret → RAS top. Low log2(INC) bits of every target are forced to 0.
- fetch_pc_o = selected target if any redirect is active, else pc_q (combinational bypass, zero-bubble redirect).
- flush_o = any redirect active, gated with valid_q.
- Update: if fetch_valid_o & fetch_ready_i, pc_q ← fetch_pc_o + INC. Else, if a redirect is active, pc_q ← target, holding the redirect across a stall. Else pc_q holds.
- RAS: call_i pushes at top+1 (circular). When count = RAS_DEPTH, the oldest entry is overwritten, count stays, and ovf_q is set.
- ret_i with count>0 pops. With count=0 it is ignored: no redirect, no pop.
- call_i & ret_i in the same cycle: the top entry is replaced by ret_addr_i, count is unchanged, and the old top is the prediction. If count=0, this is a plain push.
- ret pop happens only when ret is the winning redirect or a lower source. If trap, jr or br wins in the same cycle, ret_i/call_i are ignored.
- trap_i clears the RAS: count←0, pointer←0. ovf_q is cleared only by reset.

## Timing
- Reset (async): pc_q=RESET_PC, valid_q=0, count=0, ovf_q=0. Outputs: fetch_valid_o=0, fetch_pc_o=RESET_PC, flush_o=0, ras_empty_o=1, ras_ovf_o=0.
- valid_q rises the first clk edge after reset release. The first fetch presents RESET_PC unless a redirect is active.
- Redirect-to-fetch latency is 0 cycles. The next sequential address appears 1 cycle after acceptance.
- While fetch_valid_o=1 and fetch_ready_i=0, fetch_pc_o is stable unless a new redirect arrives. A new redirect replaces the address; the memory side must tolerate this.
- All redirect inputs are single-cycle qualified; holding them asserted re-applies them each cycle.
- Reset mid-stall or mid-redirect discards all state immediately.

## Structure
- Package pc_pkg: redirect-source enum (SRC_NONE, SRC_RET, SRC_BR, SRC_JR, SRC_TRAP) and an alignment-mask function of XLEN/INC.
- Sub-module pc_ras (circular stack: push, pop, replace, clear, empty/full, overflow strobe), parameterised by XLEN, RAS_DEPTH.
- Top: priority mux, target adders, pc_q/valid_q registers.

## Test plan
- Reset release, ready=1 for 4 cycles → fetch_pc_o 0x0, 0x4, 0x8, 0xC; valid low during reset.
- At pc 0x10, br_taken_i with base 0x10, off -8 → fetch_pc_o=0x8 same cycle, flush_o=1, next 0xC.
- jr_i target 0x203 with trap_i in the same cycle → 0x100 (trap wins). Alone → 0x200.
- ready=0 with br redirect to 0x40 pulsed for 1 cycle → fetch_pc_o stays 0x40 for the whole stall; after ready=1, 0x44.
- Push 0x1000, 0x2000, then ret_i twice, then a third ret_i → predicts 0x2000, then 0x1000. The third ret produces no redirect, and ras_empty_o=1.
- RAS_DEPTH=4, push 5 entries (A..E) → ras_ovf_o=1; pops yield E, D, C, B, then empty. A trap after 2 pushes → empty.
